// File: rtl/seg7_pkg.sv
// ============================================================================
// Module      : seg7_pkg
// Description : Shared types, decode table and parameter limits for the
//               seven-segment scanner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

  localparam int MIN_DIGITS  = 1;
  localparam int MAX_DIGITS  = 8;
  localparam int MIN_REFRESH = 2;
  localparam int IDX_W       = 3;

  // Active-high lit segments, bit 6 = A ... bit 0 = G, entry 15 first.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };

  typedef enum logic [0:0] {
    SHOW = 1'b0,
    GAP  = 1'b1
  } state_t;

  function automatic bit digits_legal(input int d);
    return (d >= MIN_DIGITS) && (d <= MAX_DIGITS);
  endfunction

  function automatic bit refresh_legal(input int r);
    return r >= MIN_REFRESH;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seven_seg_scanner_if.sv
// ============================================================================
// Module      : seven_seg_scanner_if
// Description : Control/data and display-pin bundle for the scanner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seven_seg_scanner_if
  import seg7_pkg::*;
#(
  parameter int DIGITS = 4
);
  logic                  enable;
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp_in;
  logic                  lz_blank;
  logic [6:0]            seg;
  logic                  dp;
  logic [DIGITS-1:0]     an;
  logic [IDX_W-1:0]      digit_idx;
  logic                  frame_tick;

  modport master (
    output enable, load, value, dp_in, lz_blank,
    input  seg, dp, an, digit_idx, frame_tick
  );

  modport slave (
    input  enable, load, value, dp_in, lz_blank,
    output seg, dp, an, digit_idx, frame_tick
  );
endinterface

`default_nettype wire

// File: rtl/seg7_hex_lut.sv
// ============================================================================
// Module      : seg7_hex_lut
// Description : Hex nibble to active-high seven-segment pattern.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_hex_lut
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);
  assign pattern = SEG_TABLE[nibble];
endmodule

`default_nettype wire

// File: rtl/seven_seg_scanner.sv
// ============================================================================
// Module      : seven_seg_scanner
// Description : Time-multiplexed seven-segment driver with blanking gap,
//               leading-zero suppression and selectable pin polarity.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_seg_scanner
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYCLES   = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  seven_seg_scanner_if.slave   bus
);

  localparam int CNT_MAX_A = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > 2) ? CNT_MAX_A : 2;
  localparam int CNT_W     = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic             SEG_INV   = (SEG_ACTIVE_LOW != 0);
  localparam logic             AN_INV    = (AN_ACTIVE_LOW != 0);

  generate
    if (!digits_legal(DIGITS) || !refresh_legal(REFRESH_DIV)) begin : g_bad_params
      $error("seven_seg_scanner: DIGITS must be 1..8 and REFRESH_DIV >= 2");
    end
  endgenerate

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [4*DIGITS-1:0]   r_shadow_val;
  logic [DIGITS-1:0]     r_shadow_dp;
  logic [6:0]            r_seg;
  logic                  r_dp;
  logic [DIGITS-1:0]     r_an;
  logic                  r_frame_tick;

  logic [3:0]            w_nibble;
  logic                  w_dp_sel;
  logic                  w_upper_nz;
  logic [6:0]            w_pattern;
  logic                  w_an_on;
  logic                  w_blank;
  logic [DIGITS-1:0]     w_onehot;
  logic                  w_wrap;
  logic [IDX_W-1:0]      w_idx_next;

  // Digit select plus "any non-zero nibble at or above idx" for zero suppression.
  always_comb begin
    w_nibble   = 4'h0;
    w_dp_sel   = 1'b0;
    w_upper_nz = 1'b0;
    w_onehot   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nibble    = r_shadow_val[4*i +: 4];
        w_dp_sel    = r_shadow_dp[i];
        w_onehot[i] = w_an_on;
      end
      if ((IDX_W'(i) >= r_idx) && (r_shadow_val[4*i +: 4] != 4'h0)) begin
        w_upper_nz = 1'b1;
      end
    end
  end

  seg7_hex_lut u_lut (
    .nibble  (w_nibble),
    .pattern (w_pattern)
  );

  assign w_an_on    = bus.enable && (r_state == SHOW);
  assign w_blank    = bus.lz_blank && (r_idx != '0) && !w_upper_nz;
  assign w_wrap     = (r_idx == IDX_LAST);
  assign w_idx_next = w_wrap ? '0 : r_idx + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= SHOW;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_shadow_val <= '0;
      r_shadow_dp  <= '0;
      r_seg        <= {7{SEG_INV}};
      r_dp         <= SEG_INV;
      r_an         <= {DIGITS{AN_INV}};
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= 1'b0;
      if (bus.load) begin
        r_shadow_val <= bus.value;
        r_shadow_dp  <= bus.dp_in;
      end
      if (bus.enable) begin
        case (r_state)
          SHOW: begin
            if (r_cnt == SHOW_LAST) begin
              r_cnt <= '0;
              if (BLANK_CYCLES > 0) begin
                r_state <= GAP;
              end else begin
                r_idx        <= w_idx_next;
                r_frame_tick <= w_wrap;
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          GAP: begin
            if (r_cnt == GAP_LAST) begin
              r_cnt        <= '0;
              r_state      <= SHOW;
              r_idx        <= w_idx_next;
              r_frame_tick <= w_wrap;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: r_state <= SHOW;
        endcase
      end
      // Pins are built from the pre-edge scan state, hence one cycle behind it.
      r_seg <= ((w_an_on && !w_blank) ? w_pattern : 7'h00) ^ {7{SEG_INV}};
      r_dp  <= (w_an_on && w_dp_sel) ^ SEG_INV;
      r_an  <= w_onehot ^ {DIGITS{AN_INV}};
    end
  end

  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.an         = r_an;
  assign bus.digit_idx  = r_idx;
  assign bus.frame_tick = r_frame_tick;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
// ============================================================================
// Module      : tb_seven_seg_scanner
// Description : Scoreboard bench driving four scanner configurations at once.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_seven_seg_scanner;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [7:0] an;
    logic [2:0] idx;
    logic       ft;
  } obs_t;

  localparam int N = 4;
  localparam int CFG_D   [N] = '{4, 4, 4, 3};
  localparam int CFG_R   [N] = '{4, 4, 4, 2};
  localparam int CFG_B   [N] = '{2, 0, 2, 1};
  localparam int CFG_SAL [N] = '{1, 1, 0, 1};
  localparam int CFG_AAL [N] = '{1, 1, 0, 0};

  string SEGS [16] = '{"ABCDEF", "BC", "ABDEG", "ABCDG", "BCFG", "ACDFG", "ACDEFG", "ABC",
                       "ABCDEFG", "ABCDFG", "ABCEFG", "CDEFG", "ADEF", "BCDEG", "ADEFG", "AEFG"};

  logic        clk;
  logic        rst;
  logic        s_en, s_ld, s_lz;
  logic [31:0] s_val;
  logic [7:0]  s_dpi;

  int          pos    [N];
  logic [31:0] sh_val [N];
  logic [7:0]  sh_dp  [N];
  obs_t        q      [N][$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cycle    = 0;

  seven_seg_scanner_if #(.DIGITS(4)) if0 ();
  seven_seg_scanner_if #(.DIGITS(4)) if1 ();
  seven_seg_scanner_if #(.DIGITS(4)) if2 ();
  seven_seg_scanner_if #(.DIGITS(3)) if3 ();

  assign if0.enable = s_en; assign if0.load = s_ld; assign if0.lz_blank = s_lz;
  assign if0.value = s_val[15:0]; assign if0.dp_in = s_dpi[3:0];
  assign if1.enable = s_en; assign if1.load = s_ld; assign if1.lz_blank = s_lz;
  assign if1.value = s_val[15:0]; assign if1.dp_in = s_dpi[3:0];
  assign if2.enable = s_en; assign if2.load = s_ld; assign if2.lz_blank = s_lz;
  assign if2.value = s_val[15:0]; assign if2.dp_in = s_dpi[3:0];
  assign if3.enable = s_en; assign if3.load = s_ld; assign if3.lz_blank = s_lz;
  assign if3.value = s_val[11:0]; assign if3.dp_in = s_dpi[2:0];

  seven_seg_scanner #(.DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(2),
                      .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  seven_seg_scanner #(.DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(0),
                      .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1))
    dut1 (.clk(clk), .rst(rst), .bus(if1));
  seven_seg_scanner #(.DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(2),
                      .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0))
    dut2 (.clk(clk), .rst(rst), .bus(if2));
  seven_seg_scanner #(.DIGITS(3), .REFRESH_DIV(2), .BLANK_CYCLES(1),
                      .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(0))
    dut3 (.clk(clk), .rst(rst), .bus(if3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] ref_pattern(input logic [3:0] h);
    logic [6:0] p;
    string      lit;
    p   = 7'h00;
    lit = SEGS[h];
    for (int c = 0; c < lit.len(); c++) p[6 - (int'(lit[c]) - 65)] = 1'b1;
    return p;
  endfunction

  // The scan is a position within a frame of DIGITS slots, each REFRESH_DIV
  // lit cycles followed by BLANK_CYCLES dark ones.
  task automatic predict(input int k);
    obs_t       e;
    int         slot, frame, d;
    logic       an_on, blank, dp_lit;
    logic [6:0] p;
    logic [31:0] vmask;
    slot  = CFG_R[k] + CFG_B[k];
    frame = CFG_D[k] * slot;
    vmask = 32'((64'd1 << (4 * CFG_D[k])) - 64'd1);
    e     = '0;
    if (rst) begin
      an_on = 1'b0; blank = 1'b0; dp_lit = 1'b0; d = 0;
      pos[k] = 0; sh_val[k] = 32'h0; sh_dp[k] = 8'h0;
    end else begin
      d      = pos[k] / slot;
      an_on  = s_en && ((pos[k] % slot) < CFG_R[k]);
      blank  = s_lz && (d > 0) && ((sh_val[k] >> (4 * d)) == 32'h0);
      dp_lit = an_on && sh_dp[k][d];
      e.ft   = s_en && (pos[k] == frame - 1);
    end
    p     = (an_on && !blank) ? ref_pattern(sh_val[k][4*d +: 4]) : 7'h00;
    e.seg = (CFG_SAL[k] != 0) ? ~p : p;
    e.dp  = (CFG_SAL[k] != 0) ? !dp_lit : dp_lit;
    for (int i = 0; i < CFG_D[k]; i++) begin
      e.an[i] = ((an_on && i == d) ? 1'b1 : 1'b0) ^ (CFG_AAL[k] != 0);
    end
    if (!rst) begin
      if (s_en) pos[k] = (pos[k] + 1) % frame;
      if (s_ld) begin
        sh_val[k] = s_val & vmask;
        sh_dp[k]  = s_dpi & 8'((9'd1 << CFG_D[k]) - 9'd1);
      end
    end
    e.idx = 3'(pos[k] / slot);
    q[k].push_back(e);
  endtask

  task automatic step(input logic r, input logic e, input logic l,
                      input logic [31:0] v, input logic [7:0] dpv, input logic lz);
    @(negedge clk);
    rst = r; s_en = e; s_ld = l; s_val = v; s_dpi = dpv; s_lz = lz;
    for (int k = 0; k < N; k++) predict(k);
  endtask

  task automatic run(input int n, input logic lz);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 8'h0, lz);
  endtask

  task automatic check(input int k, input obs_t act);
    obs_t exp;
    if (q[k].size() == 0) return;
    exp = q[k].pop_front();
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL dut%0d cycle %0d seg/dp/an/idx/tick: actual %b/%b/%b/%0d/%b required %b/%b/%b/%0d/%b",
               k, cycle, act.seg, act.dp, act.an, act.idx, act.ft,
               exp.seg, exp.dp, exp.an, exp.idx, exp.ft);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      check(0, {if0.seg, if0.dp, 8'(if0.an), if0.digit_idx, if0.frame_tick});
      check(1, {if1.seg, if1.dp, 8'(if1.an), if1.digit_idx, if1.frame_tick});
      check(2, {if2.seg, if2.dp, 8'(if2.an), if2.digit_idx, if2.frame_tick});
      check(3, {if3.seg, if3.dp, 8'(if3.an), if3.digit_idx, if3.frame_tick});
    end
  end

  initial begin
    rst = 1'b1; s_en = 1'b0; s_ld = 1'b0; s_val = 32'h0; s_dpi = 8'h0; s_lz = 1'b0;
    step(1'b1, 1'b1, 1'b1, 32'hFFFF, 8'hFF, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 8'h0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h12AF, 8'h00, 1'b0);
    run(60, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h0030, 8'h00, 1'b1);
    run(30, 1'b1);
    step(1'b0, 1'b1, 1'b1, 32'h0000, 8'h06, 1'b1);
    run(30, 1'b1);
    step(1'b0, 1'b1, 1'b1, 32'h12AF, 8'h05, 1'b0);
    run(9, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 8'h0, 1'b0);
    run(30, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h8888, 8'h00, 1'b0);
    run(30, 1'b0);
    run(3, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h5555, 8'hFF, 1'b0);
    run(30, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 15) == 0), $urandom >> (4 * $urandom_range(0, 8)),
           8'($urandom), 1'($urandom_range(0, 1)));
    end
    @(posedge clk);
    #2;
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if (q[k].size() != 0) begin
        n_fail++;
        $display("FAIL dut%0d leftover: actual %0d pending required 0", k, q[k].size());
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
